// File: rtl/fma_bank.sv
// Bank of signed fixed-point fused multiply-add lanes sharing one strobe.
// Two-stage pipeline with per-lane accumulator for chained dot products.
module fma_bank #(
  parameter int FMA_COUNT = 2,
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [3*WIDTH-1:0]   abc_in       [FMA_COUNT],
  input  logic                 c_valid_in   [FMA_COUNT],
  input  logic                 abc_valid_in,
  input  logic                 clear_acc_in,
  output logic [WIDTH-1:0]     d_out        [FMA_COUNT],
  output logic                 d_valid_out,
  output logic                 overflow_out [FMA_COUNT],
  output logic                 ready_out,
  output logic                 drop_error_out
);

  logic                   s1_valid;
  logic                   accept;
  logic signed [2*WIDTH-1:0] prod_q [FMA_COUNT];
  logic [WIDTH-1:0]       csel_q [FMA_COUNT];
  logic [WIDTH-1:0]       acc    [FMA_COUNT];

  logic signed [2*WIDTH-1:0] prod_d [FMA_COUNT];
  logic [WIDTH-1:0]       csel_d [FMA_COUNT];
  logic [2*WIDTH:0]       sum    [FMA_COUNT];
  logic [WIDTH-1:0]       res    [FMA_COUNT];
  logic                   ovf    [FMA_COUNT];

  assign ready_out = !s1_valid;
  assign accept    = abc_valid_in && ready_out;

  always_comb begin
    for (int unsigned i = 0; i < FMA_COUNT; i++) begin
      prod_d[i] = '0;
      csel_d[i] = '0;
      sum[i]    = '0;
      res[i]    = '0;
      ovf[i]    = 1'b0;
    end
    for (int unsigned i = 0; i < FMA_COUNT; i++) begin
      // Operands sign-extended to 2W so the product is exact before the shift.
      prod_d[i] = ($signed({{WIDTH{abc_in[i][3*WIDTH-1]}}, abc_in[i][3*WIDTH-1:2*WIDTH]}) *
                   $signed({{WIDTH{abc_in[i][2*WIDTH-1]}}, abc_in[i][2*WIDTH-1:WIDTH]}))
                  >>> FRAC_BITS;
      csel_d[i] = c_valid_in[i] ? abc_in[i][WIDTH-1:0]
                                : (clear_acc_in ? '0 : acc[i]);
      sum[i] = {prod_q[i][2*WIDTH-1], prod_q[i]} +
               {{(WIDTH+1){csel_q[i][WIDTH-1]}}, csel_q[i]};
      // In range only when every bit above the result's sign bit matches it.
      ovf[i] = !((&sum[i][2*WIDTH:WIDTH-1]) || !(|sum[i][2*WIDTH:WIDTH-1]));
      if (ovf[i])
        res[i] = sum[i][2*WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else
        res[i] = sum[i][WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid       <= 1'b0;
      d_valid_out    <= 1'b0;
      drop_error_out <= 1'b0;
      for (int unsigned i = 0; i < FMA_COUNT; i++) begin
        prod_q[i]       <= '0;
        csel_q[i]       <= '0;
        acc[i]          <= '0;
        d_out[i]        <= '0;
        overflow_out[i] <= 1'b0;
      end
    end else begin
      s1_valid    <= accept;
      d_valid_out <= s1_valid;
      if (abc_valid_in && !ready_out)
        drop_error_out <= 1'b1;
      for (int unsigned i = 0; i < FMA_COUNT; i++) begin
        if (accept) begin
          prod_q[i] <= prod_d[i];
          csel_q[i] <= csel_d[i];
        end
        // A result being written, or just written, wins over a clear request.
        if (s1_valid) begin
          d_out[i]        <= res[i];
          acc[i]          <= res[i];
          overflow_out[i] <= ovf[i];
        end else if (clear_acc_in && !d_valid_out) begin
          acc[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fma_bank.sv
// Directed-vector bench for fma_bank at default parameters (2 lanes, Q8.8).
module tb_fma_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] abc     [2];
  logic        c_valid [2];
  logic        abc_valid;
  logic        clear_acc;
  logic [15:0] d       [2];
  logic        d_valid;
  logic        ovf     [2];
  logic        ready;
  logic        drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fma_bank #(.FMA_COUNT(2), .WIDTH(16), .FRAC_BITS(8)) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .abc_in         (abc),
    .c_valid_in     (c_valid),
    .abc_valid_in   (abc_valid),
    .clear_acc_in   (clear_acc),
    .d_out          (d),
    .d_valid_out    (d_valid),
    .overflow_out   (ovf),
    .ready_out      (ready),
    .drop_error_out (drop)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_lanes(input logic [15:0] a0, b0, c0, input logic cv0,
                           input logic [15:0] a1, b1, c1, input logic cv1);
    abc[0] = {a0, b0, c0}; c_valid[0] = cv0;
    abc[1] = {a1, b1, c1}; c_valid[1] = cv1;
  endtask

  // One accepted strobe, checked at N+1 (busy) and N+2 (result).
  task automatic run_op(input string tag,
                        input logic [15:0] a0, b0, c0, input logic cv0,
                        input logic [15:0] a1, b1, c1, input logic cv1,
                        input logic clr, input logic clr_mid,
                        input logic [15:0] e0, e1, input logic o0, o1);
    @(negedge clk);
    check_value({tag, "/idle_dvalid"}, d_valid, 0);
    set_lanes(a0, b0, c0, cv0, a1, b1, c1, cv1);
    abc_valid = 1'b1;
    clear_acc = clr;
    @(negedge clk);
    abc_valid = 1'b0;
    clear_acc = clr_mid;
    check_value({tag, "/busy_ready"}, ready, 0);
    check_value({tag, "/busy_dvalid"}, d_valid, 0);
    @(negedge clk);
    clear_acc = 1'b0;
    check_value({tag, "/dvalid"}, d_valid, 1);
    check_value({tag, "/ready"}, ready, 1);
    check_value({tag, "/d0"}, d[0], e0);
    check_value({tag, "/d1"}, d[1], e1);
    check_value({tag, "/ovf0"}, ovf[0], o0);
    check_value({tag, "/ovf1"}, ovf[1], o1);
  endtask

  initial begin
    rst = 1'b1; abc_valid = 1'b0; clear_acc = 1'b0;
    set_lanes(16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    repeat (3) @(negedge clk);
    check_value("rst/d0", d[0], 0);
    check_value("rst/d1", d[1], 0);
    check_value("rst/ovf0", ovf[0], 0);
    check_value("rst/dvalid", d_valid, 0);
    check_value("rst/ready", ready, 1);
    check_value("rst/drop", drop, 0);
    rst = 1'b0;

    run_op("mac", 16'h0180, 16'h0200, 16'h0040, 1, 16'h0200, 16'h0100, 16'h0010, 1,
           0, 0, 16'h0340, 16'h0210, 0, 0);
    run_op("chain", 16'h0100, 16'h0100, 16'h7777, 0, 16'h0100, 16'h0080, 16'h7777, 0,
           0, 0, 16'h0440, 16'h0290, 0, 0);

    @(negedge clk); clear_acc = 1'b1;
    @(negedge clk); clear_acc = 1'b0;
    check_value("clr/dvalid", d_valid, 0);
    check_value("clr/d0_hold", d[0], 16'h0440);
    check_value("clr/d1_hold", d[1], 16'h0290);

    run_op("after_clr", 16'h0100, 16'h0100, 16'h0000, 0, 16'h0100, 16'h0080, 16'h0000, 0,
           0, 0, 16'h0100, 16'h0080, 0, 0);
    run_op("sign", 16'hFF00, 16'h0080, 16'h0000, 1, 16'h0001, 16'h0001, 16'h0000, 1,
           0, 0, 16'hFF80, 16'h0000, 0, 0);
    run_op("trunc_sat", 16'hFFFF, 16'h0001, 16'h0000, 1, 16'h7FFF, 16'h7FFF, 16'h0000, 1,
           0, 0, 16'hFFFF, 16'h7FFF, 0, 1);
    run_op("sat_neg", 16'h8000, 16'h7FFF, 16'h8000, 1, 16'h0100, 16'h0100, 16'h0000, 0,
           0, 0, 16'h8000, 16'h7FFF, 1, 1);
    run_op("clr_strobe", 16'h0100, 16'h0100, 16'h1234, 0, 16'h0200, 16'h0100, 16'h0005, 1,
           1, 0, 16'h0100, 16'h0205, 0, 0);
    run_op("clr_mid", 16'h0100, 16'h0100, 16'h0000, 0, 16'h0100, 16'h0100, 16'h0000, 0,
           0, 1, 16'h0200, 16'h0305, 0, 0);
    run_op("clr_mid_chain", 16'h0100, 16'h0100, 16'h0000, 0, 16'h0100, 16'h0100, 16'h0000, 0,
           0, 0, 16'h0300, 16'h0405, 0, 0);

    // Strobes at N and N+1: second one is dropped.
    @(negedge clk);
    set_lanes(16'h0100, 16'h0100, 16'h0000, 1, 16'h0100, 16'h0100, 16'h0001, 1);
    abc_valid = 1'b1;
    @(negedge clk);
    set_lanes(16'h0200, 16'h0100, 16'h0000, 1, 16'h0200, 16'h0100, 16'h0000, 1);
    check_value("b2b/ready_low", ready, 0);
    check_value("b2b/drop_pre", drop, 0);
    @(negedge clk);
    abc_valid = 1'b0;
    check_value("b2b/dvalid", d_valid, 1);
    check_value("b2b/d0", d[0], 16'h0100);
    check_value("b2b/d1", d[1], 16'h0101);
    check_value("b2b/drop", drop, 1);
    @(negedge clk);
    check_value("b2b/dvalid_n3", d_valid, 0);
    check_value("b2b/drop_n3", drop, 1);
    @(negedge clk);
    check_value("b2b/dvalid_n4", d_valid, 0);
    check_value("b2b/d0_hold", d[0], 16'h0100);

    // Strobes at N and N+2: both accepted, second chains on the first result.
    @(negedge clk);
    set_lanes(16'h0100, 16'h0100, 16'h0000, 0, 16'h0100, 16'h0100, 16'h0000, 0);
    abc_valid = 1'b1;
    @(negedge clk);
    abc_valid = 1'b0;
    check_value("gap2/ready_low", ready, 0);
    @(negedge clk);
    check_value("gap2/dvalid_a", d_valid, 1);
    check_value("gap2/d0_a", d[0], 16'h0200);
    check_value("gap2/d1_a", d[1], 16'h0201);
    check_value("gap2/ready_a", ready, 1);
    set_lanes(16'h0200, 16'h0100, 16'h0000, 0, 16'h0080, 16'h0200, 16'h0010, 1);
    abc_valid = 1'b1;
    @(negedge clk);
    abc_valid = 1'b0;
    check_value("gap2/ready_low_b", ready, 0);
    check_value("gap2/dvalid_gap", d_valid, 0);
    @(negedge clk);
    check_value("gap2/dvalid_b", d_valid, 1);
    check_value("gap2/d0_b", d[0], 16'h0400);
    check_value("gap2/d1_b", d[1], 16'h0110);

    // Reset in the cycle after an accepted strobe.
    @(negedge clk);
    set_lanes(16'h7FFF, 16'h7FFF, 16'h0000, 1, 16'h0100, 16'h0100, 16'h0000, 1);
    abc_valid = 1'b1;
    @(negedge clk);
    abc_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_value("rstmid/dvalid", d_valid, 0);
    check_value("rstmid/d0", d[0], 0);
    check_value("rstmid/d1", d[1], 0);
    check_value("rstmid/ovf0", ovf[0], 0);
    check_value("rstmid/ready", ready, 1);
    check_value("rstmid/drop", drop, 0);
    @(negedge clk);
    check_value("rstmid/dvalid_late", d_valid, 0);

    run_op("post_rst", 16'h0100, 16'h0100, 16'h0000, 0, 16'h0100, 16'h0100, 16'h0000, 0,
           0, 0, 16'h0100, 16'h0100, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
